// File: rtl/stg_ma_mp_pkg.sv
// Shared constants and helpers for the memory-address (MA) stage.
//   SIZE_ADDR     : memory address width used across the pipeline
//   HBIT_ADDR     : MSB index of a memory address
//   MA_NPORTS_MAX : largest supported number of memory address ports
//   ma_load_e     : source selected for the MA output register each cycle
package stg_ma_mp_pkg;

  localparam int SIZE_ADDR     = 24;
  localparam int HBIT_ADDR     = SIZE_ADDR - 1;
  localparam int MA_NPORTS_MAX = 8;

  typedef enum logic [1:0] {
    LOAD_NONE = 2'd0,
    LOAD_IN   = 2'd1,
    LOAD_SKID = 2'd2
  } ma_load_e;

  function automatic bit ma_nports_ok(input int n);
    return (n >= 2) && (n <= MA_NPORTS_MAX);
  endfunction

endpackage

// File: rtl/stg_ma_mp_if.sv
// EX -> MA -> MO link bundle for the MA stage.
//   iw_valid/ow_ready          : upstream handshake (EX side)
//   iw_payload/iw_mem_req/iw_addr : op side-band, memory flag, memory address
//   iw_flush                   : discard every held op
//   ow_valid/iw_ready          : downstream handshake (MO side)
//   ow_payload/ow_mem_req/ow_mem_port : output op and its port tag
//   ow_mem_addr/ow_mem_addr_we : port address registers and their load pulse
// slave is the stage view, master the surrounding pipeline view.
interface stg_ma_mp_if
  import stg_ma_mp_pkg::*;
#(
  parameter int W_PAYLOAD = 64,
  parameter int W_ADDR    = SIZE_ADDR,
  parameter int N_PORTS   = 2
);
  localparam int W_PTR = $clog2(N_PORTS);

  logic                      iw_valid;
  logic                      ow_ready;
  logic [W_PAYLOAD-1:0]      iw_payload;
  logic                      iw_mem_req;
  logic [W_ADDR-1:0]         iw_addr;
  logic                      iw_flush;
  logic                      ow_valid;
  logic                      iw_ready;
  logic [W_PAYLOAD-1:0]      ow_payload;
  logic                      ow_mem_req;
  logic [W_PTR-1:0]          ow_mem_port;
  logic [N_PORTS*W_ADDR-1:0] ow_mem_addr;
  logic [N_PORTS-1:0]        ow_mem_addr_we;

  modport slave (
    input  iw_valid, iw_payload, iw_mem_req, iw_addr, iw_flush, iw_ready,
    output ow_ready, ow_valid, ow_payload, ow_mem_req, ow_mem_port,
           ow_mem_addr, ow_mem_addr_we
  );

  modport master (
    output iw_valid, iw_payload, iw_mem_req, iw_addr, iw_flush, iw_ready,
    input  ow_ready, ow_valid, ow_payload, ow_mem_req, ow_mem_port,
           ow_mem_addr, ow_mem_addr_we
  );

endinterface

// File: rtl/stg_ma_port_file.sv
// Memory address port registers for the MA stage.
//   iw_clk/iw_rst : clock, asynchronous active-high reset
//   we/wr_sel/wr_addr : load wr_addr into port wr_sel when we is high
//   addr_flat     : all port registers, port p at [p*W_ADDR +: W_ADDR]
//   we_pulse      : one-hot, port p was loaded on the previous edge
// Registers keep their value until the port is assigned again.
module stg_ma_port_file #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 24,
  parameter int W_PTR   = 1
) (
  input  logic                      iw_clk,
  input  logic                      iw_rst,
  input  logic                      we,
  input  logic [W_PTR-1:0]          wr_sel,
  input  logic [W_ADDR-1:0]         wr_addr,
  output logic [N_PORTS*W_ADDR-1:0] addr_flat,
  output logic [N_PORTS-1:0]        we_pulse
);

  logic [W_ADDR-1:0]  addr_p1 [N_PORTS];
  logic [N_PORTS-1:0] we_pulse_p1;

  // ---- stage boundary: port registers ----
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      for (int p = 0; p < N_PORTS; p++) addr_p1[p] <= '0;
      we_pulse_p1 <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (we && (wr_sel == W_PTR'(p))) begin
          addr_p1[p]     <= wr_addr;
          we_pulse_p1[p] <= 1'b1;
        end else begin
          we_pulse_p1[p] <= 1'b0;
        end
      end
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_flat
    assign addr_flat[p*W_ADDR +: W_ADDR] = addr_p1[p];
  end

  assign we_pulse = we_pulse_p1;

endmodule

// File: rtl/stg_ma_mp.sv
// Memory-address pipeline stage between EX and MO.
//   iw_clk/iw_rst : clock, asynchronous active-high reset
//   bus (slave)   : EX-side and MO-side handshakes, op side-band, flush,
//                   port tag and port address registers (see stg_ma_mp_if)
// One output register plus one skid entry; ow_ready depends only on skid
// occupancy, so there is no combinational path from iw_ready. Memory ops are
// assigned round-robin to N_PORTS address ports; both pointers advance per
// accepted transfer only, so stalls and flushes keep MA and MO in step.
module stg_ma_mp
  import stg_ma_mp_pkg::*;
#(
  parameter int W_PAYLOAD = 64,
  parameter int W_ADDR    = SIZE_ADDR,
  parameter int N_PORTS   = 2
) (
  input  logic        iw_clk,
  input  logic        iw_rst,
  stg_ma_mp_if.slave  bus
);

  localparam int W_PTR = $clog2(N_PORTS);
  localparam logic [W_PTR-1:0] PTR_LAST = W_PTR'(N_PORTS - 1);

  if (!ma_nports_ok(N_PORTS)) begin : g_bad_nports
    $error("stg_ma_mp: N_PORTS must be in 2..%0d", MA_NPORTS_MAX);
  end

  // Explicit wrap so non-power-of-two port counts work.
  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic                 in_fire, out_fire, skid_load;
  ma_load_e             out_load;
  logic [W_PTR-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;

  logic                 skid_vld_p0;
  logic [W_PAYLOAD-1:0] skid_payload_p0;
  logic                 skid_mem_req_p0;
  logic [W_PTR-1:0]     skid_tag_p0;

  logic                 out_vld_p1;
  logic [W_PAYLOAD-1:0] out_payload_p1;
  logic                 out_mem_req_p1;
  logic [W_PTR-1:0]     out_tag_p1;

  always_comb begin
    in_fire   = bus.iw_valid & ~skid_vld_p0 & ~bus.iw_flush;
    out_fire  = out_vld_p1 & bus.iw_ready;
    out_load  = LOAD_NONE;
    skid_load = 1'b0;
    if (skid_vld_p0) begin
      // Skid drains first; input is blocked while it is occupied.
      if (out_fire) out_load = LOAD_SKID;
    end else if (in_fire) begin
      if (!out_vld_p1 || out_fire) out_load  = LOAD_IN;
      else                         skid_load = 1'b1;
    end
    rd_ptr_nxt = (out_fire && out_mem_req_p1) ? ptr_inc(rd_ptr) : rd_ptr;
  end

  // ---- stage boundary: control (valids, pointers) ----
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      out_vld_p1  <= 1'b0;
      skid_vld_p0 <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (bus.iw_flush) begin
        // Realign allocation to the consumer so the next op gets rd_ptr.
        out_vld_p1  <= 1'b0;
        skid_vld_p0 <= 1'b0;
        wr_ptr      <= rd_ptr_nxt;
      end else begin
        case (out_load)
          LOAD_IN:   out_vld_p1 <= 1'b1;
          LOAD_SKID: begin
            out_vld_p1  <= 1'b1;
            skid_vld_p0 <= 1'b0;
          end
          default:   if (out_fire) out_vld_p1 <= 1'b0;
        endcase
        if (skid_load) skid_vld_p0 <= 1'b1;
        if (in_fire && bus.iw_mem_req) wr_ptr <= ptr_inc(wr_ptr);
      end
    end
  end

  // ---- stage boundary: skid and output data ----
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      skid_payload_p0 <= '0;
      skid_mem_req_p0 <= 1'b0;
      skid_tag_p0     <= '0;
      out_payload_p1  <= '0;
      out_mem_req_p1  <= 1'b0;
      out_tag_p1      <= '0;
    end else if (!bus.iw_flush) begin
      if (skid_load) begin
        skid_payload_p0 <= bus.iw_payload;
        skid_mem_req_p0 <= bus.iw_mem_req;
        skid_tag_p0     <= wr_ptr;
      end
      case (out_load)
        LOAD_IN: begin
          out_payload_p1 <= bus.iw_payload;
          out_mem_req_p1 <= bus.iw_mem_req;
          out_tag_p1     <= wr_ptr;
        end
        LOAD_SKID: begin
          out_payload_p1 <= skid_payload_p0;
          out_mem_req_p1 <= skid_mem_req_p0;
          out_tag_p1     <= skid_tag_p0;
        end
        default: ;
      endcase
    end
  end

  stg_ma_port_file #(
    .N_PORTS (N_PORTS),
    .W_ADDR  (W_ADDR),
    .W_PTR   (W_PTR)
  ) u_port_file (
    .iw_clk    (iw_clk),
    .iw_rst    (iw_rst),
    .we        (in_fire & bus.iw_mem_req),
    .wr_sel    (wr_ptr),
    .wr_addr   (bus.iw_addr),
    .addr_flat (bus.ow_mem_addr),
    .we_pulse  (bus.ow_mem_addr_we)
  );

  assign bus.ow_ready    = ~skid_vld_p0;
  assign bus.ow_valid    = out_vld_p1;
  assign bus.ow_payload  = out_payload_p1;
  assign bus.ow_mem_req  = out_mem_req_p1;
  assign bus.ow_mem_port = out_tag_p1;

endmodule

// File: tb/tb_stg_ma_mp.sv
// Bench for stg_ma_mp: two instances (2 and 3 ports) share one stimulus
// stream and are compared each cycle against a queue-based model of the
// held ops, port allocation counters and port contents.
module tb_stg_ma_mp;

  localparam int WP = 64;
  localparam int WA = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          t_valid, t_mem, t_flush, t_ready;
  logic [WP-1:0] t_payload;
  logic [WA-1:0] t_addr;

  stg_ma_mp_if #(.W_PAYLOAD(WP), .W_ADDR(WA), .N_PORTS(2)) bus2 ();
  stg_ma_mp_if #(.W_PAYLOAD(WP), .W_ADDR(WA), .N_PORTS(3)) bus3 ();

  assign bus2.iw_valid   = t_valid;
  assign bus2.iw_payload = t_payload;
  assign bus2.iw_mem_req = t_mem;
  assign bus2.iw_addr    = t_addr;
  assign bus2.iw_flush   = t_flush;
  assign bus2.iw_ready   = t_ready;
  assign bus3.iw_valid   = t_valid;
  assign bus3.iw_payload = t_payload;
  assign bus3.iw_mem_req = t_mem;
  assign bus3.iw_addr    = t_addr;
  assign bus3.iw_flush   = t_flush;
  assign bus3.iw_ready   = t_ready;

  stg_ma_mp #(.W_PAYLOAD(WP), .W_ADDR(WA), .N_PORTS(2)) u_dut2 (
    .iw_clk (clk), .iw_rst (rst), .bus (bus2.slave));
  stg_ma_mp #(.W_PAYLOAD(WP), .W_ADDR(WA), .N_PORTS(3)) u_dut3 (
    .iw_clk (clk), .iw_rst (rst), .bus (bus3.slave));

  typedef struct {
    logic [WP-1:0] pl;
    logic          mem;
    int            tag2;
    int            tag3;
  } op_t;

  op_t           q[$];
  int            wr2, rd2, wr3, rd3;
  int            we2_idx, we3_idx;
  logic [WA-1:0] p2 [2];
  logic [WA-1:0] p3 [3];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wr2 = 0; rd2 = 0; wr3 = 0; rd3 = 0;
    we2_idx = -1; we3_idx = -1;
    for (int i = 0; i < 2; i++) p2[i] = '0;
    for (int i = 0; i < 3; i++) p3[i] = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready2"}, bus2.ow_ready, 1);
    chk({tag, "_ready3"}, bus3.ow_ready, 1);
    chk({tag, "_valid2"}, bus2.ow_valid, 0);
    chk({tag, "_valid3"}, bus3.ow_valid, 0);
    chk({tag, "_payload"}, bus2.ow_payload, 0);
    chk({tag, "_memreq"}, bus3.ow_mem_req, 0);
    chk({tag, "_port2"}, bus2.ow_mem_port, 0);
    chk({tag, "_port3"}, bus3.ow_mem_port, 0);
    chk({tag, "_addr2"}, bus2.ow_mem_addr, 0);
    chk({tag, "_addr3"}, bus3.ow_mem_addr, 0);
    chk({tag, "_we2"}, bus2.ow_mem_addr_we, 0);
    chk({tag, "_we3"}, bus3.ow_mem_addr_we, 0);
  endtask

  task automatic check_outputs();
    logic [47:0] e2;
    logic [71:0] e3;
    for (int i = 0; i < 2; i++) e2[i*WA +: WA] = p2[i];
    for (int i = 0; i < 3; i++) e3[i*WA +: WA] = p3[i];
    chk("ready2", bus2.ow_ready, q.size() < 2);
    chk("ready3", bus3.ow_ready, q.size() < 2);
    chk("valid2", bus2.ow_valid, q.size() > 0);
    chk("valid3", bus3.ow_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("payload2", bus2.ow_payload, q[0].pl);
      chk("payload3", bus3.ow_payload, q[0].pl);
      chk("memreq2", bus2.ow_mem_req, q[0].mem);
      chk("memreq3", bus3.ow_mem_req, q[0].mem);
      chk("port2", bus2.ow_mem_port, q[0].tag2);
      chk("port3", bus3.ow_mem_port, q[0].tag3);
    end
    chk("addr2", bus2.ow_mem_addr, e2);
    chk("addr3", bus3.ow_mem_addr, e3);
    chk("we2", bus2.ow_mem_addr_we, (we2_idx >= 0) ? (128'd1 << we2_idx) : 128'd0);
    chk("we3", bus3.ow_mem_addr_we, (we3_idx >= 0) ? (128'd1 << we3_idx) : 128'd0);
  endtask

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_update();
    bit inf, outf;
    op_t o;
    inf  = t_valid && (q.size() < 2) && !t_flush;
    outf = (q.size() > 0) && t_ready;
    we2_idx = -1; we3_idx = -1;
    if (t_flush) begin
      if (outf && q[0].mem) begin
        rd2 = (rd2 + 1) % 2;
        rd3 = (rd3 + 1) % 3;
      end
      q.delete();
      wr2 = rd2; wr3 = rd3;
    end else begin
      if (outf) begin
        if (q[0].mem) begin
          rd2 = (rd2 + 1) % 2;
          rd3 = (rd3 + 1) % 3;
        end
        q.delete(0);
      end
      if (inf) begin
        o.pl = t_payload; o.mem = t_mem; o.tag2 = wr2; o.tag3 = wr3;
        q.push_back(o);
        if (t_mem) begin
          p2[wr2] = t_addr; we2_idx = wr2; wr2 = (wr2 + 1) % 2;
          p3[wr3] = t_addr; we3_idx = wr3; wr3 = (wr3 + 1) % 3;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [WP-1:0] pl, input logic mem,
                      input logic [WA-1:0] addr, input logic fl, input logic rdy);
    @(negedge clk);
    check_outputs();
    t_valid = v; t_payload = pl; t_mem = mem; t_addr = addr;
    t_flush = fl; t_ready = rdy;
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    t_valid = 0; t_payload = '0; t_mem = 0; t_addr = '0; t_flush = 0; t_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;

    // Streaming memory ops at full rate.
    for (int i = 0; i < 4; i++)
      step(1'b1, 64'hA000 + 64'(i), 1'b1, 24'h10 + 24'(i), 1'b0, 1'b1);
    idle(2);

    // Backpressure: second op lands in skid, third is held off.
    step(1'b1, 64'hB0, 1'b1, 24'h20, 1'b0, 1'b0);
    step(1'b1, 64'hB1, 1'b1, 24'h21, 1'b0, 1'b0);
    step(1'b1, 64'hB2, 1'b1, 24'h22, 1'b0, 1'b0);
    step(1'b1, 64'hB2, 1'b1, 24'h22, 1'b0, 1'b1);
    step(1'b1, 64'hB2, 1'b1, 24'h22, 1'b0, 1'b1);
    idle(3);

    // Seven memory ops walk every port of both instances through a wrap.
    for (int i = 0; i < 7; i++)
      step(1'b1, 64'hC0 + 64'(i), 1'b1, 24'h30 + 24'(i), 1'b0, 1'b1);
    idle(2);

    // Memory / ALU / memory: the ALU op keeps the current tag.
    step(1'b1, 64'hD0, 1'b1, 24'h40, 1'b0, 1'b1);
    step(1'b1, 64'hD1, 1'b0, 24'h41, 1'b0, 1'b1);
    step(1'b1, 64'hD2, 1'b1, 24'h42, 1'b0, 1'b1);
    idle(2);

    // Flush with output and skid both occupied, then flush while draining.
    step(1'b1, 64'hE0, 1'b1, 24'h50, 1'b0, 1'b0);
    step(1'b1, 64'hE1, 1'b1, 24'h51, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 64'hE2, 1'b1, 24'h52, 1'b0, 1'b1);
    step(1'b1, 64'hE3, 1'b1, 24'h53, 1'b0, 1'b0);
    step(1'b1, 64'hE4, 1'b1, 24'h54, 1'b1, 1'b1);
    step(1'b1, 64'hE5, 1'b1, 24'h55, 1'b0, 1'b1);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) != 0,
           24'($urandom), ($urandom % 16) == 0, ($urandom % 3) != 0);

    // Asynchronous reset while stalled with the skid full.
    step(1'b1, 64'hF0, 1'b1, 24'h60, 1'b0, 1'b0);
    step(1'b1, 64'hF1, 1'b1, 24'h61, 1'b0, 1'b0);
    step(1'b1, 64'hF2, 1'b1, 24'h62, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();
    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst");
    model_reset();
    t_valid = 0; t_flush = 0; t_ready = 1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      step(1'b1, 64'h100 + 64'(i), 1'b1, 24'h70 + 24'(i), 1'b0, 1'b1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
